// File: rtl/alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl -- multicycle datapath sequencer (Moore FSM).
//
// Steps one instruction at a time through fetch, decode, execute, memory and
// write-back states. It drives the enables and mux selects of a shared-ALU
// multicycle datapath.
//
// Optional feature (compile-time macro):
//   MEM_WAIT_EN  When defined, FETCH, MEMRD and MEMWR stall until mem_ready=1.
//                While stalled, mem_read/mem_write stay high and the
//                ir_write/pc_write strobes wait for mem_ready.
//                When undefined, mem_ready is ignored and each memory state
//                lasts one cycle.
//
// Ports:
//   clk            in   single clock, rising edge
//   rst            in   synchronous active-high reset (forces FETCH, blanks outputs)
//   opcode[5:0]    in   instruction opcode, stable from DECODE onward
//   mem_ready      in   memory completion strobe (MEM_WAIT_EN only)
//   pc_write       out  unconditional PC load
//   pc_write_cond  out  PC load qualified by ALU zero (branch)
//   i_or_d         out  memory address select: 0 PC, 1 ALU out
//   mem_read       out  memory read strobe
//   mem_write      out  memory write strobe
//   ir_write       out  instruction register load
//   mem_to_reg     out  register write data select: 1 memory data
//   reg_dst        out  destination register select: 1 rd, 0 rt
//   reg_write      out  register file write enable
//   alu_src_a      out  ALU A select: 0 PC, 1 reg A
//   alu_src_b[1:0] out  ALU B select: 00 B, 01 4, 10 imm, 11 imm<<2
//   alu_ct_op[1:0] out  ALU op class: 00 add, 01 sub, 10 funct, 11 compare
//   pc_source[1:0] out  PC mux: 00 ALU result, 01 ALU out, 10 jump target
//   state[3:0]     out  current state code (debug)
//   illegal        out  high while in ILLEGAL
// ---------------------------------------------------------------------------
module alu_seq_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_ct_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_IMM_EX   = 4'd10,
        S_IMM_WB   = 4'd11,
        S_ILLEGAL  = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    state_e state_q;
    state_e state_d;

    // Memory handshake qualifier. It is tied high when wait states are not
    // built, so the memory states always advance after one cycle.
    logic mem_ok;
`ifdef MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_ok           = 1'b1;
`endif

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ok) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:           state_d = S_RTYPE_EX;
                    OP_LW, OP_SW:       state_d = S_MEMADR;
                    OP_BEQ:             state_d = S_BRANCH;
                    OP_J:               state_d = S_JUMP;
                    OP_ADDIU, OP_SLTI:  state_d = S_IMM_EX;
                    default:            state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    if (mem_ok) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWR:    if (mem_ok) state_d = S_FETCH;
            S_RTYPE_EX: state_d = S_RTYPE_WB;
            S_RTYPE_WB: state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_IMM_EX:   state_d = S_IMM_WB;
            S_IMM_WB:   state_d = S_FETCH;
            // ILLEGAL is sticky; only rst leaves it.
            S_ILLEGAL:  state_d = S_ILLEGAL;
            // Codes 13-15 recover to FETCH.
            default:    state_d = S_FETCH;
        endcase
    end

    // State register: reset wins over every transition and over mem_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore output decode from the state register. Outputs are blanked while
    // rst is high, so a state that reset interrupts issues no strobes
    // (for example, no write-back after an aborted load). FETCH strobes start
    // in the cycle after rst drops.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_ct_op     = 2'b00;
        pc_source     = 2'b00;
        illegal       = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    // Commit IR and PC+4 only on the cycle the fetch completes.
                    ir_write  = mem_ok;
                    pc_write  = mem_ok;
                    alu_src_b = 2'b01;
                end
                S_DECODE: begin
                    // Compute the branch target early: PC + (imm << 2).
                    alu_src_b = 2'b11;
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_RTYPE_EX: begin
                    alu_src_a = 1'b1;
                    alu_ct_op = 2'b10;
                end
                S_RTYPE_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_ct_op     = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                S_IMM_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    // slti needs a compare; addiu is a plain add.
                    alu_ct_op = (opcode == OP_SLTI) ? 2'b11 : 2'b00;
                end
                S_IMM_WB: begin
                    reg_write = 1'b1;
                end
                S_ILLEGAL: begin
                    illegal = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign state = rst ? 4'd0 : state_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_ctrl -- scoreboard bench for alu_seq_ctrl.
// The stimulus process drives one cycle per step and queues the expected
// output vector for that cycle. The monitor pops and compares on each falling
// edge.
// ---------------------------------------------------------------------------
module tb_alu_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
    logic [1:0] alu_src_b, alu_ct_op, pc_source;
    logic [3:0] state;

    alu_seq_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .pc_write_cond(pc_write_cond),
        .i_or_d       (i_or_d),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .ir_write     (ir_write),
        .mem_to_reg   (mem_to_reg),
        .reg_dst      (reg_dst),
        .reg_write    (reg_write),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_ct_op    (alu_ct_op),
        .pc_source    (pc_source),
        .state        (state),
        .illegal      (illegal)
    );

    always #5 clk = ~clk;

    // Vector field order:
    // state[4], illegal, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
    // ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
    // alu_src_b[2], alu_ct_op[2], pc_source[2]
    logic [20:0] act;
    assign act = {state, illegal, pc_write, pc_write_cond, i_or_d, mem_read,
                  mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
                  alu_src_a, alu_src_b, alu_ct_op, pc_source};

    localparam logic [20:0] E_RST      = 21'd0;
    localparam logic [20:0] E_FETCH    = {4'd0,  1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 2'b01,2'b00,2'b00};
    localparam logic [20:0] E_FWAIT    = {4'd0,  1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b01,2'b00,2'b00};
    localparam logic [20:0] E_DECODE   = {4'd1,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b11,2'b00,2'b00};
    localparam logic [20:0] E_MEMADR   = {4'd2,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b10,2'b00,2'b00};
    localparam logic [20:0] E_MEMRD    = {4'd3,  1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,2'b00};
    localparam logic [20:0] E_MEMWB    = {4'd4,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 2'b00,2'b00,2'b00};
    localparam logic [20:0] E_MEMWR    = {4'd5,  1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,2'b00};
    localparam logic [20:0] E_RTEX     = {4'd6,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00,2'b10,2'b00};
    localparam logic [20:0] E_RTWB     = {4'd7,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 2'b00,2'b00,2'b00};
    localparam logic [20:0] E_BR       = {4'd8,  1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00,2'b01,2'b01};
    localparam logic [20:0] E_JMP      = {4'd9,  1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,2'b10};
    localparam logic [20:0] E_IMEX_ADD = {4'd10, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b10,2'b00,2'b00};
    localparam logic [20:0] E_IMEX_SLT = {4'd10, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b10,2'b11,2'b00};
    localparam logic [20:0] E_IMWB     = {4'd11, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 2'b00,2'b00,2'b00};
    localparam logic [20:0] E_ILL      = {4'd12, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,2'b00};

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_ADI = 6'b001001;
    localparam logic [5:0] OP_SLT = 6'b001010;
    localparam logic [5:0] OP_BAD = 6'b111111;

    logic [20:0] exp_q[$];
    string       name_q[$];
    int          tests = 0;
    int          fails = 0;
    logic        done  = 1'b0;

    // One cycle: drive just after the rising edge and queue what the outputs
    // must show for the rest of that cycle.
    task automatic step(input logic r, input logic [5:0] op, input logic mr,
                        input logic [20:0] e, input string nm);
        @(posedge clk);
        #1;
        rst       = r;
        opcode    = op;
        mem_ready = mr;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [20:0] e;
        string       nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            tests++;
            if (act !== e) begin
                fails++;
                $display("FAIL %s: got %h expected %h", nm, act, e);
            end
            tests++;
            if ($countones({mem_read, mem_write, reg_write}) > 1) begin
                fails++;
                $display("FAIL %s_mem_reg_excl: got %b expected at most one of mem_read/mem_write/reg_write",
                         nm, {mem_read, mem_write, reg_write});
            end
        end else if (done) begin
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        opcode    = OP_R;
        mem_ready = 1'b1;

        step(1, OP_R, 1, E_RST, "reset0");
        step(1, OP_R, 1, E_RST, "reset1");

        // R-type: 0,1,6,7
        step(0, OP_R, 1, E_FETCH,  "r_fetch");
        step(0, OP_R, 1, E_DECODE, "r_decode");
        step(0, OP_R, 1, E_RTEX,   "r_ex");
        step(0, OP_R, 1, E_RTWB,   "r_wb");

        // lw: 0,1,2,3,4
        step(0, OP_LW, 1, E_FETCH,  "lw_fetch");
        step(0, OP_LW, 1, E_DECODE, "lw_decode");
        step(0, OP_LW, 1, E_MEMADR, "lw_memadr");
        step(0, OP_LW, 1, E_MEMRD,  "lw_memrd");
        step(0, OP_LW, 1, E_MEMWB,  "lw_memwb");

        // sw: 0,1,2,5
        step(0, OP_SW, 1, E_FETCH,  "sw_fetch");
        step(0, OP_SW, 1, E_DECODE, "sw_decode");
        step(0, OP_SW, 1, E_MEMADR, "sw_memadr");
        step(0, OP_SW, 1, E_MEMWR,  "sw_memwr");

        // slti / addiu
        step(0, OP_SLT, 1, E_FETCH,    "slti_fetch");
        step(0, OP_SLT, 1, E_DECODE,   "slti_decode");
        step(0, OP_SLT, 1, E_IMEX_SLT, "slti_ex");
        step(0, OP_SLT, 1, E_IMWB,     "slti_wb");
        step(0, OP_ADI, 1, E_FETCH,    "addiu_fetch");
        step(0, OP_ADI, 1, E_DECODE,   "addiu_decode");
        step(0, OP_ADI, 1, E_IMEX_ADD, "addiu_ex");
        step(0, OP_ADI, 1, E_IMWB,     "addiu_wb");

        // beq / j
        step(0, OP_BEQ, 1, E_FETCH,  "beq_fetch");
        step(0, OP_BEQ, 1, E_DECODE, "beq_decode");
        step(0, OP_BEQ, 1, E_BR,     "beq_branch");
        step(0, OP_J,   1, E_FETCH,  "j_fetch");
        step(0, OP_J,   1, E_DECODE, "j_decode");
        step(0, OP_J,   1, E_JMP,    "j_jump");

        // Reset during MEMRD: blanked, then FETCH, never write-back
        step(0, OP_LW, 1, E_FETCH,  "lwr_fetch");
        step(0, OP_LW, 1, E_DECODE, "lwr_decode");
        step(0, OP_LW, 1, E_MEMADR, "lwr_memadr");
        step(1, OP_LW, 1, E_RST,    "lwr_rst_in_memrd");
        step(0, OP_LW, 1, E_FETCH,  "lwr_refetch");

        // Illegal opcode: sticky for 10 cycles, cleared only by rst
        step(0, OP_BAD, 1, E_DECODE, "ill_decode");
        for (int i = 0; i < 10; i++) step(0, OP_BAD, 1, E_ILL, "ill_hold");
        step(1, OP_BAD, 1, E_RST,    "ill_rst");
        step(0, OP_R,   1, E_FETCH,  "ill_refetch");
        step(0, OP_R,   1, E_DECODE, "ill_redecode");
        step(0, OP_R,   1, E_RTEX,   "ill_r_ex");
        step(0, OP_R,   1, E_RTWB,   "ill_r_wb");

`ifdef MEM_WAIT_EN
        // Fetch stalls while mem_ready is low
        for (int i = 0; i < 3; i++) step(0, OP_SW, 0, E_FWAIT, "fetch_wait");
        step(0, OP_SW, 1, E_FETCH,  "fetch_go");
        step(0, OP_SW, 1, E_DECODE, "wait_decode");
        step(0, OP_SW, 1, E_MEMADR, "wait_memadr");
        step(0, OP_SW, 0, E_MEMWR,  "memwr_wait");
        step(0, OP_SW, 1, E_MEMWR,  "memwr_go");
        step(0, OP_SW, 1, E_FETCH,  "wait_next_fetch");
`else
        // mem_ready is ignored: each memory state still lasts one cycle
        step(0, OP_LW, 0, E_FETCH,  "nowait_fetch");
        step(0, OP_LW, 0, E_DECODE, "nowait_decode");
        step(0, OP_LW, 0, E_MEMADR, "nowait_memadr");
        step(0, OP_LW, 0, E_MEMRD,  "nowait_memrd");
        step(0, OP_LW, 0, E_MEMWB,  "nowait_memwb");
        step(0, OP_LW, 0, E_FETCH,  "nowait_next_fetch");
`endif

        @(posedge clk);
        #1;
        done = 1'b1;
    end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have no parameters; opcodes and state codes are fixed constants.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 opcode  in  6  instruction opcode from the instruction register, stable from DECODE onward.
REQ-005 mem_ready  in  1  memory completion strobe; used only with MEM_WAIT_EN.
REQ-006 pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  out  1 each  datapath enables and selects.
REQ-007 alu_src_b  out  2  ALU B select: 00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-008 alu_ct_op  out  2  op class to the ALU control decoder: 00 add, 01 sub, 10 R-type funct, 11 compare.
REQ-009 pc_source  out  2  PC mux: 00 ALU result, 01 ALU out register, 10 jump target.
REQ-010 state  out  4  current state code (debug).
REQ-011 illegal  out  1  high while in ILLEGAL state.

Function
REQ-012 SHALL be a Moore FSM; all outputs decoded from the registered state (and opcode in IMM_EX only); unlisted outputs 0.
REQ-013 States/codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPE_EX 6, RTYPE_WB 7, BRANCH 8, JUMP 9, IMM_EX 10, IMM_WB 11, ILLEGAL 12; codes 13-15 unreachable and SHALL go to FETCH.
REQ-014 FETCH: mem_read=1, ir_write=1, pc_write=1, alu_src_b=01, alu_ct_op=00; next DECODE.
REQ-015 DECODE: alu_src_b=11, alu_ct_op=00; next by opcode: 000000 RTYPE_EX, 100011/101011 MEMADR, 000100 BRANCH, 000010 JUMP, 001001/001010 IMM_EX, other ILLEGAL.
REQ-016 MEMADR: alu_src_a=1, alu_src_b=10, alu_ct_op=00; next MEMRD if opcode 100011, else MEMWR.
REQ-017 MEMRD: mem_read=1, i_or_d=1; next MEMWB.  MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; next FETCH.
REQ-018 MEMWR: mem_write=1, i_or_d=1; next FETCH.
REQ-019 RTYPE_EX: alu_src_a=1, alu_src_b=00, alu_ct_op=10; next RTYPE_WB.  RTYPE_WB: reg_write=1, reg_dst=1; next FETCH.
REQ-020 IMM_EX: alu_src_a=1, alu_src_b=10, alu_ct_op=11 if opcode 001010 else 00; next IMM_WB.  IMM_WB: reg_write=1, reg_dst=0; next FETCH.
REQ-021 BRANCH: alu_src_a=1, alu_src_b=00, alu_ct_op=01, pc_write_cond=1, pc_source=01; next FETCH.
REQ-022 JUMP: pc_write=1, pc_source=10; next FETCH.
REQ-023 ILLEGAL: illegal=1, all other outputs 0; held until rst.
REQ-024 Instruction latency without MEM_WAIT_EN: lw 5, sw 4, R-type 4, addiu/slti 4, beq 3, j 3 cycles.
REQ-025 No two of mem_read, mem_write, reg_write SHALL be high in the same cycle except none.

Reset
REQ-026 rst=1 at a clock edge SHALL force state FETCH on that edge, regardless of current state, including mid-instruction and ILLEGAL.
REQ-027 While rst=1 all outputs SHALL be 0 and state=0; FETCH outputs begin the first cycle after rst deasserts.
REQ-028 rst SHALL take priority over mem_ready and all transitions.

Configuration
REQ-029 Macro MEM_WAIT_EN: when defined, FETCH, MEMRD and MEMWR SHALL hold state while mem_ready=0, with mem_read/mem_write held high and ir_write, pc_write gated by mem_ready; advance on the cycle mem_ready=1.
REQ-030 Without MEM_WAIT_EN, mem_ready SHALL be ignored and every memory state lasts exactly one cycle.

Verification
REQ-031 rst 1 then 0, opcode 000000 -> states 0,1,6,7,0; alu_ct_op=10 in state 6; reg_dst=1, reg_write=1 in state 7.
REQ-032 opcode 100011 -> states 0,1,2,3,4,0; mem_to_reg=1 in 4; opcode 101011 -> 0,1,2,5,0 with mem_write=1 only in 5.
REQ-033 opcode 001010 -> alu_ct_op=11 in IMM_EX; opcode 001001 -> alu_ct_op=00; opcode 000100 -> alu_ct_op=01, pc_write_cond=1 in state 8.
REQ-034 opcode 111111 -> state 12, illegal=1 held 10 cycles; rst 1 -> state 0 next edge, illegal=0.
REQ-035 rst asserted in MEMRD -> state 0 next edge, no reg_write pulse observed.
REQ-036 MEM_WAIT_EN: mem_ready=0 for 3 cycles in FETCH -> state 0 held, ir_write=0; mem_ready=1 -> ir_write=pc_write=1 once, then DECODE.
